// File: rtl/traceback_unit_pkg.sv
// traceback_unit_pkg: widths and state type shared by the Viterbi traceback unit
package traceback_unit_pkg;
    localparam int WD_STATE       = 8;
    localparam int WD_RAM_DATA    = 8;
    localparam int WD_RAM_ADDRESS = 11;
    localparam int WD_FSM         = 6;
    localparam int N_ACS          = 1 << WD_STATE;
    localparam int SEL_W          = $clog2(WD_RAM_DATA);
    localparam int ADDR_W         = WD_RAM_ADDRESS - WD_FSM;
    typedef logic [WD_STATE-1:0] state_t;
endpackage

// File: rtl/traceback_unit_if.sv
// traceback_unit_if: control, survivor RAM and decoded-output signals of the traceback unit
interface traceback_unit_if;
    import traceback_unit_pkg::*;
    logic                   TB_EN;
    logic                   Init;
    logic                   Hold;
    state_t                 InitState;
    logic [WD_RAM_DATA-1:0] DataTB;
    logic [ADDR_W-1:0]      AddressTB;
    logic                   DecodedData;
    state_t                 OutStateTB;
    modport master (output TB_EN, Init, Hold, InitState, DataTB,
                    input AddressTB, DecodedData, OutStateTB);
    modport slave  (input TB_EN, Init, Hold, InitState, DataTB,
                    output AddressTB, DecodedData, OutStateTB);
endinterface

// File: rtl/traceback_unit_trace_step.sv
// traceback_unit_trace_step: state register walking the trellis backwards one survivor bit per step
module traceback_unit_trace_step
    import traceback_unit_pkg::*;
(
    input  logic                   Clock1,
    input  logic                   Reset,
    input  logic                   step,
    input  logic                   init,
    input  state_t                 init_state,
    input  logic [WD_RAM_DATA-1:0] data,
    output state_t                 state,
    output logic [ADDR_W-1:0]      address
);
    logic survivor_bit;
    // upper state bits pick the RAM word, lower bits pick the survivor inside it
    assign address      = state[WD_STATE-1:SEL_W];
    assign survivor_bit = data[state[SEL_W-1:0]];
    always_ff @(posedge Clock1 or negedge Reset)
        if (!Reset) state <= '0;
        else if (init) state <= init_state;
        else if (step) state <= {state[WD_STATE-2:0], survivor_bit};
endmodule

// File: rtl/traceback_unit.sv
// traceback_unit: Viterbi traceback with decoded-bit output gated by the decode window
module traceback_unit
    import traceback_unit_pkg::*;
(
    input logic       Clock1,
    input logic       Reset,
    traceback_unit_if.slave bus
);
    if (WD_STATE != ADDR_W + SEL_W) begin : g_bad_state_width
        $error("WD_STATE must equal ADDR_W + SEL_W");
    end
    if ((1 << SEL_W) != WD_RAM_DATA) begin : g_bad_ram_width
        $error("WD_RAM_DATA must be a power of two");
    end
    traceback_unit_trace_step u_step (
        .Clock1     (Clock1),
        .Reset      (Reset),
        .step       (bus.TB_EN),
        .init       (bus.Init),
        .init_state (bus.InitState),
        .data       (bus.DataTB),
        .state      (bus.OutStateTB),
        .address    (bus.AddressTB)
    );
    // the bit leaving the state MSB is the decoded bit; Init suppresses the step
    always_ff @(posedge Clock1 or negedge Reset)
        if (!Reset) bus.DecodedData <= 1'b0;
        else if (!bus.Init && bus.TB_EN && bus.Hold) bus.DecodedData <= bus.OutStateTB[WD_STATE-1];
endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit: directed checks of traceback stepping, decode gating and async reset
module tb_traceback_unit;
    logic Clock1 = 1'b0;
    logic Reset  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    traceback_unit_if bus ();
    traceback_unit dut (.Clock1(Clock1), .Reset(Reset), .bus(bus));
    always #5 Clock1 = ~Clock1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge Clock1);
        #1;
    endtask
    task automatic drive(input logic init, input logic en, input logic hold,
                         input logic [7:0] init_state, input logic [7:0] data);
        bus.Init = init; bus.TB_EN = en; bus.Hold = hold;
        bus.InitState = init_state; bus.DataTB = data;
    endtask
    logic [7:0] sat_seq [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] addr_seq[10] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F, 8'h1F};
    logic       a5_bits [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        drive(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            tick();
            check("reset_state", 32'(bus.OutStateTB), 32'h00);
            check("reset_dec", 32'(bus.DecodedData), 32'h0);
        end
        check("reset_addr", 32'(bus.AddressTB), 32'h00);
        drive(0, 0, 1, 8'h77, 8'hFF);
        Reset = 1'b1;
        tick();
        check("idle_state", 32'(bus.OutStateTB), 32'h00);
        check("idle_dec", 32'(bus.DecodedData), 32'h0);
        // saturation with all-ones survivor words
        drive(1, 0, 0, 8'h00, 8'hFF);
        tick();
        check("sat_init", 32'(bus.OutStateTB), 32'h00);
        drive(0, 1, 1, 8'h00, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("sat_state%0d", i), 32'(bus.OutStateTB), 32'(sat_seq[i]));
            check($sformatf("sat_addr%0d", i), 32'(bus.AddressTB), 32'(addr_seq[i]));
        end
        check("sat_dec", 32'(bus.DecodedData), 32'h1);
        // 0xA5 shifted out MSB first
        drive(1, 0, 1, 8'hA5, 8'h00);
        tick();
        check("a5_init", 32'(bus.OutStateTB), 32'hA5);
        drive(0, 1, 1, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("a5_dec%0d", i), 32'(bus.DecodedData), 32'(a5_bits[i]));
        end
        check("a5_end", 32'(bus.OutStateTB), 32'h00);
        // survivor bit selection by low state bits
        drive(1, 0, 0, 8'h03, 8'h08);
        tick();
        drive(0, 1, 1, 8'h00, 8'h08);
        tick();
        check("sel_step1", 32'(bus.OutStateTB), 32'h07);
        tick();
        check("sel_step2", 32'(bus.OutStateTB), 32'h0E);
        check("sel_addr2", 32'(bus.AddressTB), 32'h01);
        // prime DecodedData to 1, then Init must win over TB_EN
        drive(1, 0, 0, 8'h80, 8'h00);
        tick();
        drive(0, 1, 1, 8'h00, 8'h00);
        tick();
        check("prime_dec", 32'(bus.DecodedData), 32'h1);
        drive(1, 1, 1, 8'h55, 8'h00);
        tick();
        check("both_state", 32'(bus.OutStateTB), 32'h55);
        check("both_dec", 32'(bus.DecodedData), 32'h1);
        drive(0, 1, 0, 8'h00, 8'h00);
        tick();
        check("nohold_state", 32'(bus.OutStateTB), 32'hAA);
        check("nohold_dec", 32'(bus.DecodedData), 32'h1);
        drive(0, 0, 1, 8'h00, 8'hFF);
        tick();
        check("holdonly_state", 32'(bus.OutStateTB), 32'hAA);
        check("holdonly_dec", 32'(bus.DecodedData), 32'h1);
        // async reset in the middle of a traceback
        drive(0, 1, 1, 8'h00, 8'hFF);
        tick();
        check("pre_rst_state", 32'(bus.OutStateTB), 32'h55);
        check("pre_rst_dec", 32'(bus.DecodedData), 32'h1);
        #2 Reset = 1'b0;
        #1;
        check("async_state", 32'(bus.OutStateTB), 32'h00);
        check("async_dec", 32'(bus.DecodedData), 32'h0);
        check("async_addr", 32'(bus.AddressTB), 32'h00);
        tick();
        drive(0, 0, 0, 8'h00, 8'hFF);
        Reset = 1'b1;
        tick();
        check("post_rst_state", 32'(bus.OutStateTB), 32'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Traceback unit of the Viterbi decoder; sits between the survivor-path RAM and the decoded-bit output.
- Starting from a loaded state, it walks the trellis backwards one step per enabled clock.
- Each step it fetches the survivor word at an address derived from the current state, selects one survivor bit, and shifts it into the state.
- During the decode window (Hold=1) it emits the bit shifted out of the state MSB.

Parameters:
- WD_STATE, 8, width of trellis state register.
- WD_RAM_DATA, 8, width of one survivor RAM word (must be a power of two).
- WD_RAM_ADDRESS, 11, full survivor RAM address width.
- WD_FSM, 6, width of the control FSM field that forms the upper RAM address bits (driven outside this block).
- Derived SEL_W = log2(WD_RAM_DATA) = 3.
- Derived ADDR_W = WD_RAM_ADDRESS - WD_FSM = 5.
- Required: WD_STATE = ADDR_W + SEL_W; elaboration error otherwise.

Ports:
- Clock1  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- TB_EN  in  1  traceback step enable.
- Init  in  1  load InitState into state register.
- Hold  in  1  decode window; enables DecodedData update.
- InitState  in  WD_STATE  start state for traceback.
- DataTB  in  WD_RAM_DATA  survivor word read from RAM at AddressTB (combinational/same-cycle data).
- AddressTB  out  ADDR_W  survivor RAM word address, low part.
- DecodedData  out  1  decoded output bit, registered.
- OutStateTB  out  WD_STATE  current traceback state, registered; exported for observation.

Behaviour:
- Single clock domain. Reset=0 asynchronously forces OutStateTB=0 and DecodedData=0 and holds them while low. First update is on the first rising Clock1 after Reset goes high.
- Combinational outputs:
  - AddressTB = OutStateTB[WD_STATE-1:SEL_W].
  - SurvivorBit = DataTB[OutStateTB[SEL_W-1:0]].
  - No registers on these paths.
- Per rising edge, priority order:
  1. Init=1: OutStateTB <= InitState; DecodedData unchanged, even if Hold=1.
  2. else TB_EN=1: OutStateTB <= {OutStateTB[WD_STATE-2:0], SurvivorBit}; MSB is discarded. If Hold=1 also, DecodedData <= old OutStateTB[WD_STATE-1].
  3. else: all registers hold.
- Hold without TB_EN does nothing.
- Init and TB_EN both 1: Init wins and no step occurs.
- Latency:
  - State change is visible on OutStateTB one edge after the enabling cycle.
  - AddressTB follows in the same cycle.
  - DecodedData is the MSB from before the step, visible after that edge.
- Wrap: after WD_STATE steps the state is fully made of survivor bits. With constant DataTB=all-ones and InitState=0, the state saturates at 0xFF and stays there.
- X/Z on DataTB is not masked; the RAM must drive valid data whenever TB_EN=1.
- Reset asserted mid-traceback aborts immediately. Traceback restarts only via a new Init.

Decomposition:
- Shared package holds WD_STATE, WD_RAM_DATA, WD_RAM_ADDRESS, WD_FSM, N_ACS and derived SEL_W/ADDR_W, plus a state typedef of WD_STATE bits.
- One sub-module, trace_step:
  - Contents: the state register, the survivor-bit mux, address slicing.
  - Behaviour: loads InitState on Init; shifts in the selected bit on TB_EN.
  - Outputs: state and the selected bit.
- The top level adds the DecodedData register and the Hold gating.

Test Plan:
- Reset=0 with random inputs and toggling Clock1 -> OutStateTB=0x00, DecodedData=0, AddressTB=0x00. Deassert Reset -> values unchanged until an Init or TB_EN edge.
- Init=1, InitState=0x00, then TB_EN=1, Hold=1, DataTB=0xFF for 10 edges -> OutStateTB sequence 0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF,0xFF,0xFF. AddressTB tracks the state (0x00,0x00,0x00,0x01,0x03,0x07,0x0F,0x1F,...).
- InitState=0xA5, DataTB=0x00, TB_EN=1, Hold=1 -> DecodedData outputs 1,0,1,0,0,1,0,1 over 8 edges; OutStateTB ends at 0x00.
- InitState=0x03, DataTB=0x08 (only bit3 set) -> step 1 selects bit3 = 1, state becomes 0x07. Step 2 selects bit7 = 0, state becomes 0x0E.
- Init=1 and TB_EN=1 on the same edge with InitState=0x55 -> OutStateTB=0x55, DecodedData unchanged. TB_EN=1, Hold=0 for one step -> DecodedData still unchanged.
- Assert Reset=0 mid-traceback between edges -> outputs go to 0 immediately without a clock edge.
